// File: rtl/rx_serial_pkg.sv
// Shared types and constants for the rx_serial_fifo receiver.
// The optional parity feature is selected with RX_SERIAL_FIFO_PARITY_EN.
package rx_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    // Status register bit positions
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVR_BIT   = 2;
    localparam int ST_FERR_BIT  = 3;
    localparam int ST_PERR_BIT  = 4;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 9;

    // Smallest usable divisor: half of it must still be a non-zero count
    localparam logic [15:0] DIV_MIN = 16'd2;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle (the pop frees the slot).
module rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed: contents are only visible via count
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/rx_serial_fifo.sv
// 8N1 serial receiver with receive FIFO and Avalon-MM register access.
// Define RX_SERIAL_FIFO_PARITY_EN for 8E1 frames with a parity check.
module rx_serial_fifo
    import rx_serial_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rx_empty
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(DATA_BITS + 1);

    // Synchronizer and receive datapath
    logic                 rxd_s1, rxd_sync;
    rx_state_e            state, state_d;
    logic [15:0]          div_reg, div_lat, cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 expire;
    logic                 load_half, load_full, shift_en;
    logic                 push_req, set_ferr, set_perr;

    // Bus side
    logic                 rd, wr, rd_data, clr;
    logic                 ovr, ferr, perr;
    logic                 set_ovr;
    logic [31:0]          status;

    // FIFO interface
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;

    logic                 unused_wdata;
    assign unused_wdata = ^writedata[31:16];

    assign rd      = chipselect && !read_n;
    assign wr      = chipselect && !write_n;
    assign rd_data = rd && (address == ADDR_DATA);
    assign clr     = wr && (address == ADDR_STATUS);
    assign expire  = (cnt == 16'd1);
    // A pop in the same cycle frees the slot, so only a lone push into full overruns
    assign set_ovr = push_req && fifo_full && !rd_data;

    // Two-flop synchronizer on the asynchronous serial line (idle high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1   <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_sync <= rxd_s1;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state and per-sample control strobes
    always_comb begin
        state_d   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_sync) begin
                    load_half = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (expire) begin
                    if (!rxd_sync) begin
                        load_full = 1'b1;
                        state_d   = DATA;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef RX_SERIAL_FIFO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef RX_SERIAL_FIFO_PARITY_EN
            PARITY: begin
                if (expire) begin
                    load_full = 1'b1;
                    set_perr  = ((^shreg) != rxd_sync);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    if (rxd_sync) push_req = 1'b1;
                    else          set_ferr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, bit counter and shift register; divisor latched at start detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div_lat <= 16'(CLK_DIV);
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (load_half) begin
                cnt     <= div_reg >> 1;
                div_lat <= div_reg;
                bit_cnt <= '0;
            end else if (load_full) begin
                cnt <= div_lat;
            end else if (state != IDLE) begin
                cnt <= cnt - 16'd1;
            end
            if (shift_en) begin
                shreg   <= (shreg >> 1) | (DATA_BITS'(rxd_sync) << (DATA_BITS - 1));
                bit_cnt <= bit_cnt + BCW'(1);
            end
        end
    end

    rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .wdata   (shreg),
        .pop     (rd_data),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Divisor register; small values clamp so the half-bit count stays non-zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          div_reg <= 16'(CLK_DIV);
        else if (wr && address == ADDR_DIV)    div_reg <= clamp_div(writedata[15:0]);
    end

    // Sticky error flags: W1C, a set in the same cycle wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= (ovr  && !(clr && writedata[ST_OVR_BIT]))  || set_ovr;
            ferr <= (ferr && !(clr && writedata[ST_FERR_BIT])) || set_ferr;
        end
    end

`ifdef RX_SERIAL_FIFO_PARITY_EN
    // Parity error flag, same W1C / set-wins behaviour as the others
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perr <= 1'b0;
        else          perr <= (perr && !(clr && writedata[ST_PERR_BIT])) || set_perr;
    end
`else
    assign perr = 1'b0;
`endif

    // Status word assembly
    always_comb begin
        status                                = '0;
        status[ST_EMPTY_BIT]                  = fifo_empty;
        status[ST_FULL_BIT]                   = fifo_full;
        status[ST_OVR_BIT]                    = ovr;
        status[ST_FERR_BIT]                   = ferr;
        status[ST_PERR_BIT]                   = perr;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    // Registered read data, zero in every cycle that is not a read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd) begin
            case (address)
                ADDR_DATA:   readdata <= fifo_empty ? 32'd0 : 32'(fifo_head);
                ADDR_STATUS: readdata <= status;
                ADDR_DIV:    readdata <= {16'd0, div_reg};
                default:     readdata <= '0;
            endcase
        end else begin
            readdata <= '0;
        end
    end

    // Interrupt-facing empty flag, registered one cycle behind the FIFO count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_empty <= 1'b1;
        else          rx_empty <= fifo_empty;
    end

    // Parity strobe is constant low in the 8N1 build
    logic unused_perr_strobe;
    assign unused_perr_strobe = set_perr;

endmodule

// File: doc/rx_serial_fifo.md
Name: rx_serial_fifo

Overview:
Asynchronous serial (8N1) receiver with a receive FIFO and an Avalon-MM slave for CPU access. It sits directly upstream of the Rx interrupt PIO: its rx_empty output drives that PIO's single-bit input port. The PIO's falling-edge capture (empty→non-empty) raises the CPU interrupt. Software drains bytes through this block's data register.

Parameters:
CLK_DIV, 434, reset value of the baud divisor in clk cycles per bit (50 MHz / 115200).
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.
DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rxd  input  1  serial line, asynchronous, idle high
address  input  2  Avalon word address
chipselect  input  1  Avalon select
read_n  input  1  Avalon read strobe, active low
write_n  input  1  Avalon write strobe, active low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
rx_empty  output  1  high when FIFO empty; feeds the Rx PIO in_port

Behaviour:
- Reset (async, reset_n=0): readdata=0, rx_empty=1, FIFO pointers/count=0, sticky flags=0, divisor=CLK_DIV, FSM=IDLE, rxd synchronizer flops=1.
- rxd passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states:
  - IDLE: on synchronized rxd=0, load bit counter with divisor/2 → START.
  - START: at count expiry, resample. If 0 → DATA, with bit counter reloaded to divisor. If 1 → IDLE (glitch, no flag).
  - DATA: sample at each expiry, shift in LSB first. After DATA_BITS samples → STOP (→ PARITY when enabled).
  - STOP: sample at expiry. If 1: push byte, or set overrun if FIFO full (byte dropped). If 0: set frame_err, no push. → IDLE.
- Divisor is latched at the start-bit detect. Writes mid-frame take effect on the next frame. Written values <2 clamp to 2.
- Register map (readdata updated on the clock edge after the access; read latency 1):
  - addr0 R: {24'b0, FIFO head}. Pops one entry. A read while empty returns 0 with no pointer change.
  - addr1 R: status. bit0 empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err, bits[8+:9] count, other bits 0.
  - addr1 W: write-1-to-clear on bits 2..4.
  - addr2 R/W: divisor [15:0].
  - addr3: reads 0, writes ignored.
- readdata is cleared to 0 on cycles without a read, so it carries valid data only in the cycle after a read.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full, because the pop frees the slot first, so no overrun is set.
- rx_empty is driven from a register and updates the cycle after the count change. Pop of the last entry gives rx_empty=1; a push into an empty FIFO gives a 1→0 transition.
- Sticky-flag set and W1C clear in the same cycle: set wins.
- Reset asserted mid-frame: the frame is discarded and all state returns to reset values.

Optional Feature:
Macro RX_SERIAL_FIFO_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state follows DATA. A parity mismatch sets parity_err and the byte is still pushed if the stop bit is good.
- Undefined: no PARITY state; status bit4 reads 0.

Decomposition:
- Shared package rx_serial_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_DIV=2).
  - Status bit-index constants.
  - DIV_MIN=2.
- One sub-module, rx_sync_fifo: parameterised depth/width, push/pop/full/empty/count, simultaneous push+pop handled internally.

Test Plan:
- Divisor 8; send 0xA5 with a good stop bit → rx_empty falls 1→0 after the stop sample. Read addr0 → readdata=0x000000A5 the next cycle, then rx_empty=1.
- 0-pulse of 3 clks on rxd in IDLE with divisor 8 → treated as a glitch: no push, no flags, FSM back to IDLE.
- Frame with stop bit=0 → status bit3=1, count=0. Write 0x8 to addr1 → bit3 clears.
- Send 17 bytes with no reads (depth 16) → full=1, overrun=1, count=16. Reads return bytes 1..16 in order.
- Pop issued in the same cycle as a push on a full FIFO → count stays 16 and no overrun is set.
- With RX_SERIAL_FIFO_PARITY_EN: byte 0x03 with parity bit 1 → parity_err=1 and 0x03 is still pushed. Without the macro → status bit4 stays 0.
